// File: rtl/lfsr_pixel_feeder_if.sv
// Pixel stream between the LFSR pixel feeder FIFO and the VGA pixel stage.
// The feeder drives valid/rgb (master); the VGA stage drives ready (slave).
interface lfsr_pixel_feeder_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_rgb;

    modport master (
        output pix_valid,
        output pix_rgb,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_rgb,
        output pix_ready
    );
endinterface

// File: rtl/lfsr_pixel_feeder.sv
// Steps the upstream LFSR, harvests one byte every STEPS shifts, packs byte triples
// into two RGB444 pixels and queues them in a small FIFO for the VGA pixel stage.
module lfsr_pixel_feeder #(
    parameter int STEPS      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          lfsr_out,
    output logic                lfsr_en,
    input  logic                frame_start,
    output logic                underrun,
    lfsr_pixel_feeder_if.master pix
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]       LAST_STEP     = 8'(STEPS - 1);
    localparam logic [CNT_W-1:0] MAX_START_CNT = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        ST_STEP    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  step_cnt_reg;
    logic [1:0]  byte_idx_reg;
    logic [7:0]  byte0_reg;
    logic [3:0]  byte1_lo_reg;
    logic        lfsr_en_reg;
    logic        underrun_reg;

    logic [11:0]      mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic        push;
    logic [11:0] push_data;
    logic        pop;
    logic        fifo_empty;
    logic        room_for_triple;

    // Pixel A closes on byte1, pixel B on byte2; both take the live LFSR byte directly.
    always_comb begin
        push      = 1'b0;
        push_data = 12'h000;
        if (state_reg == ST_CAPTURE) begin
            if (byte_idx_reg == 2'd1) begin
                push      = 1'b1;
                push_data = {byte0_reg, lfsr_out[7:4]};
            end else if (byte_idx_reg == 2'd2) begin
                push      = 1'b1;
                push_data = {byte1_lo_reg, lfsr_out};
            end
        end
    end

    assign fifo_empty      = (count_reg == '0);
    assign pop             = ~fifo_empty & pix.pix_ready;
    // Two slots must be free before a triple starts, judged on the registered count.
    assign room_for_triple = (count_reg <= MAX_START_CNT);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Reset parks in WAIT so the first shift lands one cycle after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_WAIT;
            step_cnt_reg <= '0;
            byte_idx_reg <= '0;
            byte0_reg    <= '0;
            byte1_lo_reg <= '0;
            lfsr_en_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_STEP: begin
                    if (step_cnt_reg == LAST_STEP) begin
                        step_cnt_reg <= '0;
                        state_reg    <= ST_CAPTURE;
                        lfsr_en_reg  <= 1'b0;
                    end else begin
                        step_cnt_reg <= step_cnt_reg + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (byte_idx_reg == 2'd0) begin
                        byte0_reg <= lfsr_out;
                    end
                    if (byte_idx_reg == 2'd1) begin
                        byte1_lo_reg <= lfsr_out[3:0];
                    end
                    if (byte_idx_reg == 2'd2) begin
                        byte_idx_reg <= 2'd0;
                        state_reg    <= ST_WAIT;
                        lfsr_en_reg  <= 1'b0;
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        state_reg    <= ST_STEP;
                        lfsr_en_reg  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (room_for_triple) begin
                        state_reg   <= ST_STEP;
                        lfsr_en_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_WAIT;
                    lfsr_en_reg <= 1'b0;
                end
            endcase
        end
    end

    // frame_start has priority so a same-cycle underrun does not survive the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_reg <= 1'b0;
        end else if (frame_start) begin
            underrun_reg <= 1'b0;
        end else if (pix.pix_ready && fifo_empty) begin
            underrun_reg <= 1'b1;
        end
    end

    assign lfsr_en       = lfsr_en_reg;
    assign underrun      = underrun_reg;
    assign pix.pix_valid = ~fifo_empty;
    assign pix.pix_rgb   = fifo_empty ? 12'h000 : mem_reg[rd_ptr_reg];

endmodule

// File: tb/tb_lfsr_pixel_feeder.sv
// Self-checking bench for lfsr_pixel_feeder: cycle tables, hand-built corner sequences
// and a randomized handshake run scored against a byte-stream pixel model.
module tb_lfsr_pixel_feeder;
    localparam int STEPS      = 8;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] lfsr_out;
    logic       lfsr_en;
    logic       frame_start = 1'b0;
    logic       underrun;

    lfsr_pixel_feeder_if pix ();

    lfsr_pixel_feeder #(
        .STEPS      (STEPS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lfsr_out    (lfsr_out),
        .lfsr_en     (lfsr_en),
        .frame_start (frame_start),
        .underrun    (underrun),
        .pix         (pix)
    );

    always #5 clk = ~clk;

    // Upstream byte source: all-zero, a script indexed by completed bytes, or a real LFSR.
    typedef enum int {SRC_ZERO, SRC_SCRIPT, SRC_LFSR} src_t;
    src_t        src_mode = SRC_ZERO;
    logic        lfsr_load = 1'b0;
    logic [7:0]  seed = 8'h5A;
    logic [7:0]  lfsr_q = 8'h00;
    int unsigned shifts = 0;
    logic [7:0]  script [16];

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    always @(posedge clk) begin
        if (lfsr_load) begin
            lfsr_q <= seed;
            shifts <= 0;
        end else if (lfsr_en) begin
            lfsr_q <= lfsr_next(lfsr_q);
            shifts <= shifts + 1;
        end
    end

    always_comb begin
        case (src_mode)
            SRC_SCRIPT: lfsr_out = script[4'((shifts / STEPS) % 16)];
            SRC_LFSR:   lfsr_out = lfsr_q;
            default:    lfsr_out = 8'h00;
        endcase
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Pixel model straight from the packing rule.
    function automatic logic [11:0] pix_a(input logic [7:0] b0, input logic [7:0] b1);
        return {b0, b1[7:4]};
    endfunction
    function automatic logic [11:0] pix_b(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[3:0], b2};
    endfunction

    logic [11:0] exp_q [$];
    logic [7:0]  model_state;

    task automatic model_triple();
        logic [7:0] b [3];
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < STEPS; s++) begin
                model_state = lfsr_next(model_state);
            end
            b[k] = model_state;
        end
        exp_q.push_back(pix_a(b[0], b[1]));
        exp_q.push_back(pix_b(b[1], b[2]));
    endtask

    // Leaves the bench at the negedge of cycle 0 (first cycle after release).
    task automatic do_reset(input bit load_src);
        @(negedge clk);
        reset = 1'b1;
        lfsr_load = load_src;
        pix.pix_ready = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        lfsr_load = 1'b0;
    endtask

    // Holds ready high and scores n pops against exp_q within a cycle budget.
    task automatic expect_pixels(input int n, input int budget, input string tag);
        int got;
        logic [11:0] want;
        got = 0;
        pix.pix_ready = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pix.pix_valid) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'h000;
                check($sformatf("%s_pix%0d", tag, got), 32'(pix.pix_rgb), 32'(want));
                $display("%s pixel %0d rgb=%03h want=%03h", tag, got, pix.pix_rgb, want);
                got++;
            end
            @(negedge clk);
            if (got == n) break;
        end
        pix.pix_ready = 1'b0;
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    typedef struct {
        logic        ready;
        logic        frame;
        logic        exp_en;
        logic        exp_valid;
        logic [11:0] exp_rgb;
        logic        exp_underrun;
    } vec_t;
    vec_t tbl [$];

    function automatic logic en_window(input int c);
        return (c >= 1 && c <= 8) || (c >= 10 && c <= 17) ||
               (c >= 19 && c <= 26) || (c >= 29 && c <= 36);
    endfunction

    task automatic run_tbl(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            pix.pix_ready = tbl[i].ready;
            frame_start   = tbl[i].frame;
            $display("%s cyc %0d en=%b valid=%b rgb=%03h underrun=%b", tag, i - first,
                     lfsr_en, pix.pix_valid, pix.pix_rgb, underrun);
            check($sformatf("%s_en_c%0d", tag, i - first), 32'(lfsr_en), 32'(tbl[i].exp_en));
            check($sformatf("%s_valid_c%0d", tag, i - first), 32'(pix.pix_valid), 32'(tbl[i].exp_valid));
            check($sformatf("%s_rgb_c%0d", tag, i - first), 32'(pix.pix_rgb), 32'(tbl[i].exp_rgb));
            check($sformatf("%s_underrun_c%0d", tag, i - first), 32'(underrun), 32'(tbl[i].exp_underrun));
            @(negedge clk);
        end
        pix.pix_ready = 1'b0;
        frame_start   = 1'b0;
    endtask

    initial begin
        vec_t        v;
        logic [7:0]  snap;
        logic [11:0] want;
        logic        v_s;
        logic [11:0] rgb_s;
        logic        rdy;
        logic        frm;
        logic        exp_underrun;
        int          en_cycles;
        int          popped;
        int          drained;
        int          seen;

        pix.pix_ready = 1'b0;
        for (int i = 0; i < 16; i++) script[i] = 8'h00;

        // Table 1: zero bytes, ready low. Table 2: AB/CD/EF, ready high, frame pulses.
        for (int c = 0; c <= 30; c++) begin
            v.ready = 1'b0;
            v.frame = 1'b0;
            v.exp_en = en_window(c);
            v.exp_valid = (c >= 19);
            v.exp_rgb = 12'h000;
            v.exp_underrun = 1'b0;
            tbl.push_back(v);
        end
        for (int c = 0; c <= 30; c++) begin
            v.ready = 1'b1;
            v.frame = (c == 5 || c == 19);
            v.exp_en = en_window(c);
            v.exp_valid = (c == 19 || c == 28);
            v.exp_rgb = (c == 19) ? 12'hABC : ((c == 28) ? 12'hDEF : 12'h000);
            v.exp_underrun = !(c == 0 || c == 6 || c == 20);
            tbl.push_back(v);
        end

        src_mode = SRC_ZERO;
        do_reset(1'b1);
        run_tbl(0, 30, "zero");

        src_mode = SRC_SCRIPT;
        script[1] = 8'hAB;
        script[2] = 8'hCD;
        script[3] = 8'hEF;
        do_reset(1'b1);
        run_tbl(31, 61, "abcdef");

        // Backpressure: FIFO fills to depth, FSM parks, then drains in order and resumes.
        for (int i = 0; i < 16; i++) script[i] = 8'(i * 29 + 7);
        do_reset(1'b1);
        repeat (60) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            check($sformatf("park_en_c%0d", 60 + c), 32'(lfsr_en), 32'd0);
            check($sformatf("park_valid_c%0d", 60 + c), 32'(pix.pix_valid), 32'd1);
            @(negedge clk);
        end
        exp_q.delete();
        exp_q.push_back(pix_a(script[1], script[2]));
        exp_q.push_back(pix_b(script[2], script[3]));
        exp_q.push_back(pix_a(script[4], script[5]));
        exp_q.push_back(pix_b(script[5], script[6]));
        expect_pixels(4, 4, "drain");
        check("drain_empty", 32'(pix.pix_valid), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (lfsr_en) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("resume_en", 32'(seen), 32'd1);
        exp_q.push_back(pix_a(script[7], script[8]));
        expect_pixels(1, 100, "resume");

        // Reset during byte1 of the second triple with one pixel queued.
        src_mode = SRC_LFSR;
        do_reset(1'b1);
        exp_q.delete();
        model_state = seed;
        model_triple();
        repeat (30) @(negedge clk);
        check("mid_valid_c30", 32'(pix.pix_valid), 32'd1);
        want = exp_q.pop_front();
        check("mid_head_c30", 32'(pix.pix_rgb), 32'(want));
        pix.pix_ready = 1'b1;
        @(negedge clk);
        pix.pix_ready = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_en_c40", 32'(lfsr_en), 32'd1);
        check("mid_valid_c40", 32'(pix.pix_valid), 32'd1);
        do_reset(1'b0);
        check("rst_en", 32'(lfsr_en), 32'd0);
        check("rst_valid", 32'(pix.pix_valid), 32'd0);
        check("rst_rgb", 32'(pix.pix_rgb), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        snap = lfsr_q;
        exp_q.delete();
        model_state = snap;
        model_triple();
        expect_pixels(2, 120, "fresh");

        // Randomized handshake and frame pulses against the byte-stream model.
        do_reset(1'b1);
        exp_q.delete();
        model_state = seed;
        exp_underrun = 1'b0;
        en_cycles = 0;
        popped = 0;
        for (int c = 0; c < 10000; c++) begin
            v_s = pix.pix_valid;
            rgb_s = pix.pix_rgb;
            if (lfsr_en) en_cycles++;
            check($sformatf("rnd_underrun_c%0d", c), 32'(underrun), 32'(exp_underrun));
            if (!v_s) check($sformatf("rnd_idle_rgb_c%0d", c), 32'(rgb_s), 32'd0);
            rdy = 1'($urandom_range(0, 1));
            frm = ($urandom_range(0, 99) == 0);
            pix.pix_ready = rdy;
            frame_start = frm;
            if (v_s && rdy) begin
                if (exp_q.size() == 0) model_triple();
                want = exp_q.pop_front();
                check($sformatf("rnd_pix%0d", popped), 32'(rgb_s), 32'(want));
                $display("rnd pixel %0d rgb=%03h want=%03h", popped, rgb_s, want);
                popped++;
            end
            if (frm) exp_underrun = 1'b0;
            else if (rdy && !v_s) exp_underrun = 1'b1;
            @(negedge clk);
        end
        pix.pix_ready = 1'b0;
        frame_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (lfsr_en) en_cycles++;
            @(negedge clk);
        end
        check("rnd_park_en", 32'(lfsr_en), 32'd0);
        drained = 0;
        pix.pix_ready = 1'b1;
        for (int k = 0; k <= FIFO_DEPTH; k++) begin
            if (!pix.pix_valid) break;
            if (exp_q.size() == 0) model_triple();
            want = exp_q.pop_front();
            check($sformatf("rnd_drain%0d", drained), 32'(pix.pix_rgb), 32'(want));
            $display("rnd drain %0d rgb=%03h want=%03h", drained, pix.pix_rgb, want);
            drained++;
            @(negedge clk);
        end
        pix.pix_ready = 1'b0;
        check("rnd_drain_bounded", 32'(drained >= FIFO_DEPTH - 1 && drained <= FIFO_DEPTH), 32'd1);
        check("rnd_en_cycles", 32'(en_cycles), 32'(STEPS * 3 * (popped + drained) / 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
